// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU controller and its adder.
package alu_pkg;

  localparam int NIBBLE = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/nibble_adder_4.sv
// Combinational 4-bit carry-lookahead adder, shared by the low and high passes.
module nibble_adder_4
  import alu_pkg::*;
(
  input  logic              en,
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              c_in,
  output logic [NIBBLE-1:0] sum,
  output logic              c_out
);

  logic [NIBBLE-1:0] g;
  logic [NIBBLE-1:0] p;
  logic [NIBBLE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries expanded from generate/propagate so no ripple chain is formed.
  always_comb begin
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
  end

  // Outputs are forced quiet while the controller is not using the adder.
  assign sum   = en ? (p ^ c[NIBBLE-1:0]) : '0;
  assign c_out = en & c[NIBBLE];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequences an 8-bit add/subtract through one 4-bit adder, low nibble first.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// LO    | low nibble held on the adder for SETTLE cycles
// HI    | high nibble held on the adder with the chained carry
// FIN   | result/flags valid, done pulsed
module nibble_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       c_out,
  output logic       zero,
  output logic       neg,
  output logic       ovf
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        cy_q, cy_d;         // cy0 during LO, then cy4 during HI
  logic [3:0]  sum_lo_q, sum_lo_d;
  logic [7:0]  result_q, result_d;
  logic        c_out_q, c_out_d;
  logic        zero_q, zero_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;

  logic [NIBBLE-1:0] add_a, add_b, add_sum;
  logic              add_en, add_co;
  logic [7:0]        res_w;

  assign add_en = (state_q == ST_LO) || (state_q == ST_HI);
  assign add_a  = (state_q == ST_HI) ? a_q[7:4] : a_q[3:0];
  assign add_b  = (state_q == ST_HI) ? b_q[7:4] : b_q[3:0];

  nibble_adder_4 u_adder (
    .en    (add_en),
    .a     (add_a),
    .b     (add_b),
    .c_in  (cy_q),
    .sum   (add_sum),
    .c_out (add_co)
  );

  // Next-state, operand latch and result/flag capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    cy_d     = cy_q;
    sum_lo_d = sum_lo_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    res_w    = {add_sum, sum_lo_q};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {8{op[0]}};
          cy_d    = op[1] ? c_in : op[0];
          cnt_d   = SETTLE_M1;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (cnt_q == 4'd0) begin
          sum_lo_d = add_sum;
          cy_d     = add_co;
          cnt_d    = SETTLE_M1;
          state_d  = ST_HI;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HI: begin
        if (cnt_q == 4'd0) begin
          // Captured on the edge into FIN so the values are valid alongside done.
          result_d = res_w;
          c_out_d  = add_co;
          zero_d   = (res_w == 8'd0);
          neg_d    = res_w[7];
          ovf_d    = (a_q[7] == b_q[7]) && (res_w[7] != a_q[7]);
          state_d  = ST_FIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      sum_lo_q <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cy_q     <= cy_d;
      sum_lo_q <= sum_lo_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_FIN);
  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;

endmodule
